// File: rtl/dual_port_ram.sv
// Harvard-style RAM: read-only instruction port and byte-enabled data port over one
// shared array, with request/ack handshake, 1- or 2-cycle read latency and error flags.

module dpr_resp_pipe #(
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk_sys,
   input  logic                  rst_b,
   input  logic                  req,
   input  logic                  fail,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  ack,
   output logic                  err,
   output logic [DATA_WIDTH-1:0] data
);

   logic                  ack1;
   logic                  err1;
   logic [DATA_WIDTH-1:0] data1;

   // data only moves on a successful read, so the output holds between acks
   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         ack1  <= 1'b0;
         err1  <= 1'b0;
         data1 <= '0;
      end else begin
         ack1 <= req;
         err1 <= req & fail;
         if (load) data1 <= rdata;
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_two
         logic                  load1;
         logic                  ack2;
         logic                  err2;
         logic [DATA_WIDTH-1:0] data2;

         always_ff @(posedge clk_sys) begin
            if (!rst_b) begin
               load1 <= 1'b0;
               ack2  <= 1'b0;
               err2  <= 1'b0;
               data2 <= '0;
            end else begin
               load1 <= load;
               ack2  <= ack1;
               err2  <= err1;
               if (load1) data2 <= data1;
            end
         end

         assign ack  = ack2;
         assign err  = err2;
         assign data = data2;
      end else begin : g_one
         assign ack  = ack1;
         assign err  = err1;
         assign data = data1;
      end
   endgenerate

endmodule

module dual_port_ram #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 16,
   parameter int DEPTH        = 512,
   parameter int READ_LATENCY = 1
) (
   input  logic                    Clock,
   input  logic                    Reset_n,
   input  logic                    I_Req,
   input  logic [ADDR_WIDTH-1:0]   I_Address,
   output logic [DATA_WIDTH-1:0]   I_DataOut,
   output logic                    I_Ack,
   output logic                    I_Err,
   input  logic                    D_Read,
   input  logic                    D_Write,
   input  logic [ADDR_WIDTH-1:0]   D_Address,
   input  logic [DATA_WIDTH-1:0]   D_DataIn,
   input  logic [DATA_WIDTH/8-1:0] D_ByteEn,
   output logic [DATA_WIDTH-1:0]   D_DataOut,
   output logic                    D_Ack,
   output logic                    D_Err
);

   localparam int LANES = DATA_WIDTH / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic             i_legal;
   logic             d_legal;
   logic             d_req;
   logic             d_fail;
   logic             d_load;
   logic             d_wr_ok;
   logic [IDX_W-1:0] i_idx;
   logic [IDX_W-1:0] d_idx;
   logic [DATA_WIDTH-1:0] i_rdata;
   logic [DATA_WIDTH-1:0] d_rdata;

   assign i_legal = ({1'b0, I_Address} < LIMIT);
   assign d_legal = ({1'b0, D_Address} < LIMIT);
   assign i_idx   = I_Address[IDX_W-1:0];
   assign d_idx   = D_Address[IDX_W-1:0];
   assign i_rdata = mem[i_idx];
   assign d_rdata = mem[d_idx];

   // simultaneous read+write on the data port is a collision: neither happens
   assign d_req   = D_Read | D_Write;
   assign d_fail  = (D_Read & D_Write) | ~d_legal;
   assign d_load  = D_Read & ~D_Write & d_legal;
   assign d_wr_ok = Reset_n & D_Write & ~D_Read & d_legal;

   // storage is deliberately outside reset; nonblocking update gives old-data reads
   always_ff @(posedge Clock) begin
      if (d_wr_ok) begin
         for (int k = 0; k < LANES; k++) begin
            if (D_ByteEn[k]) mem[d_idx][8*k +: 8] <= D_DataIn[8*k +: 8];
         end
      end
   end

   dpr_resp_pipe #(
      .DATA_WIDTH  (DATA_WIDTH),
      .READ_LATENCY(READ_LATENCY)
   ) u_ipipe (
      .clk_sys(Clock),
      .rst_b  (Reset_n),
      .req    (I_Req),
      .fail   (~i_legal),
      .load   (I_Req & i_legal),
      .rdata  (i_rdata),
      .ack    (I_Ack),
      .err    (I_Err),
      .data   (I_DataOut)
   );

   dpr_resp_pipe #(
      .DATA_WIDTH  (DATA_WIDTH),
      .READ_LATENCY(READ_LATENCY)
   ) u_dpipe (
      .clk_sys(Clock),
      .rst_b  (Reset_n),
      .req    (d_req),
      .fail   (d_fail),
      .load   (d_load),
      .rdata  (d_rdata),
      .ack    (D_Ack),
      .err    (D_Err),
      .data   (D_DataOut)
   );

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed bench for dual_port_ram: one instance at read latency 1 and one at 2,
// driven by the same stimulus; the latency-2 copy is checked one cycle behind.

module tb_dual_port_ram;

   typedef struct {
      logic        i_req;
      logic [15:0] i_addr;
      logic        d_rd;
      logic        d_wr;
      logic [15:0] d_addr;
      logic [31:0] d_din;
      logic [3:0]  d_be;
      logic        e_iack;
      logic        e_ierr;
      logic [31:0] e_idout;
      logic        e_dack;
      logic        e_derr;
      logic [31:0] e_ddout;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req, d_rd, d_wr;
   logic [15:0] i_addr, d_addr;
   logic [31:0] d_din;
   logic [3:0]  d_be;

   logic [31:0] i_dout1, d_dout1, i_dout2, d_dout2;
   logic        i_ack1, i_err1, d_ack1, d_err1;
   logic        i_ack2, i_err2, d_ack2, d_err2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dual_port_ram #(
      .DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(512), .READ_LATENCY(1)
   ) u_ram1 (
      .Clock(clk), .Reset_n(rst_n),
      .I_Req(i_req), .I_Address(i_addr), .I_DataOut(i_dout1), .I_Ack(i_ack1), .I_Err(i_err1),
      .D_Read(d_rd), .D_Write(d_wr), .D_Address(d_addr), .D_DataIn(d_din), .D_ByteEn(d_be),
      .D_DataOut(d_dout1), .D_Ack(d_ack1), .D_Err(d_err1)
   );

   dual_port_ram #(
      .DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(512), .READ_LATENCY(2)
   ) u_ram2 (
      .Clock(clk), .Reset_n(rst_n),
      .I_Req(i_req), .I_Address(i_addr), .I_DataOut(i_dout2), .I_Ack(i_ack2), .I_Err(i_err2),
      .D_Read(d_rd), .D_Write(d_wr), .D_Address(d_addr), .D_DataIn(d_din), .D_ByteEn(d_be),
      .D_DataOut(d_dout2), .D_Ack(d_ack2), .D_Err(d_err2)
   );

   function automatic vec_t mk(
      input logic ir, input logic [15:0] ia,
      input logic dr, input logic dw, input logic [15:0] da,
      input logic [31:0] dd, input logic [3:0] be,
      input logic eia, input logic eie, input logic [31:0] eid,
      input logic eda, input logic ede, input logic [31:0] edd);
      vec_t v;
      v.i_req = ir;   v.i_addr = ia;
      v.d_rd = dr;    v.d_wr = dw;    v.d_addr = da;
      v.d_din = dd;   v.d_be = be;
      v.e_iack = eia; v.e_ierr = eie; v.e_idout = eid;
      v.e_dack = eda; v.e_derr = ede; v.e_ddout = edd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk_port(input string tag,
                           input logic ia, input logic ie, input logic [31:0] id,
                           input logic da, input logic de, input logic [31:0] dd,
                           input vec_t e);
      chk({tag, " i_ack"},  {31'd0, ia}, {31'd0, e.e_iack});
      chk({tag, " i_err"},  {31'd0, ie}, {31'd0, e.e_ierr});
      chk({tag, " i_dout"}, id, e.e_idout);
      chk({tag, " d_ack"},  {31'd0, da}, {31'd0, e.e_dack});
      chk({tag, " d_err"},  {31'd0, de}, {31'd0, e.e_derr});
      chk({tag, " d_dout"}, dd, e.e_ddout);
   endtask

   task automatic apply(input vec_t v);
      i_req  = v.i_req;  i_addr = v.i_addr;
      d_rd   = v.d_rd;   d_wr   = v.d_wr;   d_addr = v.d_addr;
      d_din  = v.d_din;  d_be   = v.d_be;
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      vec_t vecs[$];
      vec_t prev;
      vec_t zero;

      zero = mk(0,0, 0,0,0, 32'h0,4'h0, 0,0,32'h0, 0,0,32'h0);
      rst_n = 1'b0;
      apply(zero);
      @(negedge clk);
      tick;
      tick;
      chk_port("reset u1", i_ack1, i_err1, i_dout1, d_ack1, d_err1, d_dout1, zero);
      chk_port("reset u2", i_ack2, i_err2, i_dout2, d_ack2, d_err2, d_dout2, zero);

      // inputs | expected latency-1 outputs after the accepting edge
      vecs.push_back(mk(0,0,      0,1,5,   32'hDEADBEEF,4'hF, 0,0,32'h0,        1,0,32'h0));
      vecs.push_back(mk(0,0,      1,0,5,   32'h0,4'h0,        0,0,32'h0,        1,0,32'hDEADBEEF));
      vecs.push_back(mk(0,0,      0,1,7,   32'h11223344,4'hF, 0,0,32'h0,        1,0,32'hDEADBEEF));
      vecs.push_back(mk(0,0,      0,1,7,   32'hAABBCCDD,4'h5, 0,0,32'h0,        1,0,32'hDEADBEEF));
      vecs.push_back(mk(0,0,      1,0,7,   32'h0,4'h0,        0,0,32'h0,        1,0,32'h11BB33DD));
      vecs.push_back(mk(1,5,      0,1,3,   32'h12345678,4'hF, 1,0,32'hDEADBEEF, 1,0,32'h11BB33DD));
      vecs.push_back(mk(1,3,      0,1,3,   32'h000000FF,4'hF, 1,0,32'h12345678, 1,0,32'h11BB33DD));
      vecs.push_back(mk(1,3,      0,0,0,   32'h0,4'h0,        1,0,32'h000000FF, 0,0,32'h11BB33DD));
      vecs.push_back(mk(0,0,      0,1,0,   32'hCAFEF00D,4'hF, 0,0,32'h000000FF, 1,0,32'h11BB33DD));
      vecs.push_back(mk(1,512,    1,0,512, 32'h0,4'h0,        1,1,32'h000000FF, 1,1,32'h11BB33DD));
      vecs.push_back(mk(0,0,      1,1,0,   32'h0,4'hF,        0,0,32'h000000FF, 1,1,32'h11BB33DD));
      vecs.push_back(mk(1,0,      0,1,512, 32'h0,4'hF,        1,0,32'hCAFEF00D, 1,1,32'h11BB33DD));
      vecs.push_back(mk(0,0,      1,0,0,   32'h0,4'h0,        0,0,32'hCAFEF00D, 1,0,32'hCAFEF00D));
      vecs.push_back(mk(0,0,      0,1,0,   32'hFFFFFFFF,4'h0, 0,0,32'hCAFEF00D, 1,0,32'hCAFEF00D));
      vecs.push_back(mk(0,0,      0,1,511, 32'h0F0F0F0F,4'hF, 0,0,32'hCAFEF00D, 1,0,32'hCAFEF00D));
      vecs.push_back(mk(1,511,    1,0,0,   32'h0,4'h0,        1,0,32'h0F0F0F0F, 1,0,32'hCAFEF00D));
      vecs.push_back(mk(0,0,      1,0,511, 32'h0,4'h0,        0,0,32'h0F0F0F0F, 1,0,32'h0F0F0F0F));
      vecs.push_back(mk(0,0,      0,1,5,   32'h00112233,4'hA, 0,0,32'h0F0F0F0F, 1,0,32'h0F0F0F0F));
      vecs.push_back(mk(1,5,      1,0,5,   32'h0,4'h0,        1,0,32'h00AD22EF, 1,0,32'h00AD22EF));
      vecs.push_back(mk(0,0,      0,0,0,   32'h0,4'h0,        0,0,32'h00AD22EF, 0,0,32'h00AD22EF));
      vecs.push_back(mk(1,16'hFFFF,0,0,0,  32'h0,4'h0,        1,1,32'h00AD22EF, 0,0,32'h00AD22EF));
      vecs.push_back(mk(0,0,      0,0,0,   32'h0,4'h0,        0,0,32'h00AD22EF, 0,0,32'h00AD22EF));

      rst_n = 1'b1;
      prev = zero;
      foreach (vecs[j]) begin
         apply(vecs[j]);
         tick;
         chk_port($sformatf("u1 row %0d", j), i_ack1, i_err1, i_dout1, d_ack1, d_err1, d_dout1, vecs[j]);
         chk_port($sformatf("u2 row %0d", j), i_ack2, i_err2, i_dout2, d_ack2, d_err2, d_dout2, prev);
         prev = vecs[j];
      end
      apply(zero);
      tick;
      chk_port("u2 tail", i_ack2, i_err2, i_dout2, d_ack2, d_err2, d_dout2, prev);

      // back-to-back instruction reads through the two-stage pipeline
      apply(mk(0,0, 0,1,1, 32'h11110001,4'hF, 0,0,0, 0,0,0));
      tick;
      apply(mk(0,0, 0,1,2, 32'h22220002,4'hF, 0,0,0, 0,0,0));
      tick;
      apply(mk(1,0, 0,0,0, 32'h0,4'h0, 0,0,0, 0,0,0));
      tick;
      chk("pipe c0 u2 i_ack", {31'd0, i_ack2}, 32'd0);
      chk("pipe c0 u1 i_ack", {31'd0, i_ack1}, 32'd1);
      chk("pipe c0 u1 i_dout", i_dout1, 32'hCAFEF00D);
      apply(mk(1,1, 0,0,0, 32'h0,4'h0, 0,0,0, 0,0,0));
      tick;
      chk("pipe c1 u2 i_ack", {31'd0, i_ack2}, 32'd1);
      chk("pipe c1 u2 i_dout", i_dout2, 32'hCAFEF00D);
      chk("pipe c1 u1 i_dout", i_dout1, 32'h11110001);
      apply(mk(1,2, 0,0,0, 32'h0,4'h0, 0,0,0, 0,0,0));
      tick;
      chk("pipe c2 u2 i_ack", {31'd0, i_ack2}, 32'd1);
      chk("pipe c2 u2 i_dout", i_dout2, 32'h11110001);
      chk("pipe c2 u1 i_dout", i_dout1, 32'h22220002);
      apply(zero);
      tick;
      chk("pipe c3 u2 i_ack", {31'd0, i_ack2}, 32'd1);
      chk("pipe c3 u2 i_err", {31'd0, i_err2}, 32'd0);
      chk("pipe c3 u2 i_dout", i_dout2, 32'h22220002);
      tick;
      chk("pipe c4 u2 i_ack", {31'd0, i_ack2}, 32'd0);
      chk("pipe c4 u2 i_dout hold", i_dout2, 32'h22220002);

      // reset while a latency-2 read is in flight, plus a write attempted during reset
      apply(mk(0,0, 1,0,5, 32'h0,4'h0, 0,0,0, 0,0,0));
      tick;
      chk("rst inflight u2 d_ack", {31'd0, d_ack2}, 32'd0);
      rst_n = 1'b0;
      apply(zero);
      tick;
      chk_port("rst mid u1", i_ack1, i_err1, i_dout1, d_ack1, d_err1, d_dout1, zero);
      chk_port("rst mid u2", i_ack2, i_err2, i_dout2, d_ack2, d_err2, d_dout2, zero);
      apply(mk(0,0, 0,1,5, 32'hFFFFFFFF,4'hF, 0,0,0, 0,0,0));
      tick;
      chk("rst write u1 d_ack", {31'd0, d_ack1}, 32'd0);
      rst_n = 1'b1;
      apply(zero);
      tick;
      chk("rst rel u1 d_ack", {31'd0, d_ack1}, 32'd0);
      chk("rst rel u2 d_ack", {31'd0, d_ack2}, 32'd0);
      apply(mk(0,0, 1,0,5, 32'h0,4'h0, 0,0,0, 0,0,0));
      tick;
      chk("post rst u1 d_ack", {31'd0, d_ack1}, 32'd1);
      chk("post rst u1 d_dout", d_dout1, 32'h00AD22EF);
      apply(zero);
      tick;
      chk("post rst u2 d_ack", {31'd0, d_ack2}, 32'd1);
      chk("post rst u2 d_dout", d_dout2, 32'h00AD22EF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
